mm_stage: RTL and testbench

Memory-access stage of the data-driven pipeline, placed directly after the function-processing stage. Consumes the 40-bit result packet together with WRITE_EN / WRITE_DATA / LOAD_FLG. Performs the store or load against a local data memory. Forwards the (possibly updated) packet downstream over a synchronous Send/Ack handshake.

---
 rtl/mm_stage_pkg.sv | 42 ++++
 rtl/mm_stage_if.sv | 24 ++
 rtl/mm_ram.sv | 25 ++
 rtl/mm_stage.sv | 107 ++++++++++
 tb/tb_mm_stage.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mm_stage_pkg.sv
// Shared definitions for the memory-access stage: packet layout, field offsets and FSM states.
package mm_stage_pkg;

    localparam int PACKET_LENGTH = 40;

    localparam int COLOR_W = 3;
    localparam int GEN_W   = 8;
    localparam int DEST_W  = 7;
    localparam int LR2_W   = 2;
    localparam int DATA_W  = 16;

    localparam int DATA_OFS  = 0;
    localparam int Z_OFS     = 16;
    localparam int C_OFS     = 17;
    localparam int CPY_OFS   = 18;
    localparam int BR_OFS    = 19;
    localparam int LR2_OFS   = 20;
    localparam int DEST_OFS  = 22;
    localparam int GEN_OFS   = 29;
    localparam int COLOR_OFS = 37;

    // Field order matches the wire layout, MSB first.
    typedef struct packed {
        logic [COLOR_W-1:0] color;
        logic [GEN_W-1:0]   gen;
        logic [DEST_W-1:0]  dest;
        logic [LR2_W-1:0]   lr2;
        logic               br;
        logic               cpy;
        logic               c;
        logic               z;
        logic [DATA_W-1:0]  data;
    } packet_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/mm_stage_if.sv
// Packet/handshake bundle for mm_stage: upstream Send_in/Ack_out link and downstream Send_out/Ack_in link.
interface mm_stage_if;

    logic [mm_stage_pkg::PACKET_LENGTH-1:0] PACKET_IN;
    logic                                   WRITE_EN;
    logic [15:0]                            WRITE_DATA;
    logic                                   LOAD_FLG;
    logic                                   Send_in;
    logic                                   Ack_out;
    logic [mm_stage_pkg::PACKET_LENGTH-1:0] PACKET_OUT;
    logic                                   Send_out;
    logic                                   Ack_in;

    modport master (
        output PACKET_IN, WRITE_EN, WRITE_DATA, LOAD_FLG, Send_in, Ack_in,
        input  Ack_out, PACKET_OUT, Send_out
    );

    modport slave (
        input  PACKET_IN, WRITE_EN, WRITE_DATA, LOAD_FLG, Send_in, Ack_in,
        output Ack_out, PACKET_OUT, Send_out
    );

endinterface

// File: rtl/mm_ram.sv
// Single-port synchronous data RAM, write-first: a write also presents the written word on rdata.
module mm_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              CP,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto block RAM; contents power up undefined.
    always_ff @(posedge CP) begin
        if (we) begin
            r_mem[addr] <= wdata;
            rdata       <= wdata;
        end else begin
            rdata       <= r_mem[addr];
        end
    end

endmodule

// File: rtl/mm_stage.sv
// mm_stage: memory-access pipeline stage; performs store/load on a local RAM and forwards the packet.
// Optional build macro MM_CLEAR_EN: sweep the RAM to zero after reset before accepting packets.
module mm_stage
    import mm_stage_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic      CP,
    input  logic      MR_N,
    mm_stage_if.slave bus
);

    packet_t           r_pkt;
    packet_t           w_pkt_in;
    state_t            r_state;
    state_t            w_next;
    logic              w_ack_out;
    logic              w_in_xfer;
    logic              w_load;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

`ifdef MM_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
    logic [ADDR_W-1:0] r_clr_cnt;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    assign w_pkt_in = packet_t'(bus.PACKET_IN);
    assign w_load   = bus.LOAD_FLG & ~bus.WRITE_EN;  // store wins when both flags are set

    // Ack_out depends on state and Ack_in only; Send_in feeds w_in_xfer but never Ack_out.
    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        w_ack_out = 1'b0;
        w_next    = r_state;
        case (r_state)
            ST_IDLE: w_ack_out = 1'b1;
            ST_READ: w_next    = ST_HOLD;
            ST_HOLD: begin
                w_ack_out = bus.Ack_in;
                if (bus.Ack_in) w_next = ST_IDLE;
            end
`ifdef MM_CLEAR_EN
            ST_CLEAR: if (r_clr_cnt == '1) w_next = ST_IDLE;
`endif
            default: w_next = ST_IDLE;
        endcase
        w_in_xfer = bus.Send_in & w_ack_out;
        if (w_in_xfer) w_next = w_load ? ST_READ : ST_HOLD;
    end

    always_comb begin
        w_ram_we    = w_in_xfer & bus.WRITE_EN;
        w_ram_addr  = w_pkt_in.data[ADDR_W-1:0];
        w_ram_wdata = bus.WRITE_DATA;
`ifdef MM_CLEAR_EN
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = r_clr_cnt;
            w_ram_wdata = '0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            r_state <= RESET_STATE;
            r_pkt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_in_xfer)
                r_pkt <= w_pkt_in;
            else if (r_state == ST_READ)
                r_pkt.data <= w_ram_rdata;
        end
    end

`ifdef MM_CLEAR_EN
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N)
            r_clr_cnt <= '0;
        else if (r_state == ST_CLEAR)
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
    end
`endif

    mm_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CP    (CP),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    assign bus.Ack_out    = w_ack_out;
    assign bus.Send_out   = (r_state == ST_HOLD);
    assign bus.PACKET_OUT = r_pkt;

endmodule

// File: tb/tb_mm_stage.sv
// Directed bench for mm_stage: store/load, wrap, pass-through, both flags, backpressure, streaming, reset.
module tb_mm_stage;

    logic CP = 1'b0;
    logic MR_N;

    mm_stage_if bus();

    mm_stage #(.ADDR_W(10)) dut (
        .CP   (CP),
        .MR_N (MR_N),
        .bus  (bus)
    );

    always #5 CP = ~CP;

    int n_pass  = 0;
    int n_total = 0;

`ifdef MM_CLEAR_EN
    localparam logic RESET_ACK = 1'b0;
`else
    localparam logic RESET_ACK = 1'b1;
`endif

    function automatic logic [39:0] pk(input logic [23:0] hdr, input logic [15:0] d);
        return {hdr, d};
    endfunction

    task automatic idle_inputs();
        bus.PACKET_IN  = '0;
        bus.WRITE_EN   = 1'b0;
        bus.WRITE_DATA = '0;
        bus.LOAD_FLG   = 1'b0;
        bus.Send_in    = 1'b0;
    endtask

    // Present one beat from a negedge, wait (bounded) for Ack_out, let it transfer, then withdraw it.
    task automatic do_accept(input string name, input logic [39:0] p, input logic we,
                             input logic [15:0] wd, input logic ld);
        int waited = 0;
        bus.PACKET_IN  = p;
        bus.WRITE_EN   = we;
        bus.WRITE_DATA = wd;
        bus.LOAD_FLG   = ld;
        bus.Send_in    = 1'b1;
        while (bus.Ack_out !== 1'b1 && waited < 50) begin
            @(negedge CP);
            waited++;
        end
        n_total++;
        if (bus.Ack_out !== 1'b1)
            $display("FAIL %s_accept: Ack_out=%b after %0d cycles, required 1", name, bus.Ack_out, waited);
        else
            n_pass++;
        @(posedge CP);
        #1;
        bus.Send_in  = 1'b0;
        bus.WRITE_EN = 1'b0;
        bus.LOAD_FLG = 1'b0;
    endtask

    // Accept one beat with Ack_in=1, report cycles until Send_out and the packet seen, then drain to IDLE.
    task automatic run_beat(input string name, input logic [39:0] p, input logic we,
                            input logic [15:0] wd, input logic ld,
                            output logic [39:0] obs, output int lat);
        do_accept(name, p, we, wd, ld);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CP);
            if (bus.Send_out === 1'b1) begin
                lat = i;
                break;
            end
        end
        obs = bus.PACKET_OUT;
        @(negedge CP);
    endtask

    // Called at the negedge MR_N is released; counts edges until Ack_out rises.
    task automatic wait_clear(input string name);
        int cnt = 0;
        while (bus.Ack_out !== 1'b1 && cnt < 2000) begin
            @(posedge CP);
            #1;
            cnt++;
        end
        n_total++;
        if (cnt !== 1024) $display("FAIL %s: Ack_out low for %0d cycles, required 1024", name, cnt);
        else n_pass++;
        @(negedge CP);
    endtask

    task automatic test_reset();
        MR_N = 1'b0;
        idle_inputs();
        bus.Ack_in = 1'b1;
        repeat (2) @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b0) $display("FAIL reset_send_out: got %b, required 0", bus.Send_out);
        else n_pass++;
        n_total++;
        if (bus.PACKET_OUT !== 40'h0) $display("FAIL reset_packet_out: got %h, required 0", bus.PACKET_OUT);
        else n_pass++;
        n_total++;
        if (bus.Ack_out !== RESET_ACK) $display("FAIL reset_ack_out: got %b, required %b", bus.Ack_out, RESET_ACK);
        else n_pass++;
        MR_N = 1'b1;
`ifdef MM_CLEAR_EN
        wait_clear("reset_sweep");
`else
        @(negedge CP);
`endif
    endtask

    task automatic test_store_load();
        logic [39:0] obs;
        int          lat;
        run_beat("store5", pk(24'hA1B2C3, 16'h0005), 1'b1, 16'hBEEF, 1'b0, obs, lat);
        n_total++;
        if (lat !== 1) $display("FAIL store5_latency: got %0d, required 1", lat);
        else n_pass++;
        n_total++;
        if (obs !== pk(24'hA1B2C3, 16'h0005)) $display("FAIL store5_packet: got %h, required %h", obs, pk(24'hA1B2C3, 16'h0005));
        else n_pass++;
        run_beat("load5", pk(24'h5E6F70, 16'h0005), 1'b0, 16'h0000, 1'b1, obs, lat);
        n_total++;
        if (lat !== 2) $display("FAIL load5_latency: got %0d, required 2", lat);
        else n_pass++;
        n_total++;
        if (obs !== pk(24'h5E6F70, 16'hBEEF)) $display("FAIL load5_packet: got %h, required %h", obs, pk(24'h5E6F70, 16'hBEEF));
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [39:0] obs;
        int          lat;
        run_beat("store403", pk(24'h123456, 16'h0403), 1'b1, 16'h1234, 1'b0, obs, lat);
        n_total++;
        if (obs !== pk(24'h123456, 16'h0403)) $display("FAIL store403_packet: got %h, required %h", obs, pk(24'h123456, 16'h0403));
        else n_pass++;
        run_beat("load003", pk(24'h0F0F0F, 16'h0003), 1'b0, 16'h0000, 1'b1, obs, lat);
        n_total++;
        if (obs !== pk(24'h0F0F0F, 16'h1234)) $display("FAIL wrap_load: got %h, required %h", obs, pk(24'h0F0F0F, 16'h1234));
        else n_pass++;
    endtask

    task automatic test_pass_through();
        logic [39:0] obs;
        int          lat;
        run_beat("prestore", pk(24'h000000, 16'h00FF), 1'b1, 16'hABCD, 1'b0, obs, lat);
        // Header ends in C=1, Z=0; WRITE_DATA must be ignored without WRITE_EN.
        run_beat("pass", pk(24'h3C5A02, 16'h00FF), 1'b0, 16'h9999, 1'b0, obs, lat);
        n_total++;
        if (lat !== 1) $display("FAIL pass_latency: got %0d, required 1", lat);
        else n_pass++;
        n_total++;
        if (obs !== pk(24'h3C5A02, 16'h00FF)) $display("FAIL pass_packet: got %h, required %h", obs, pk(24'h3C5A02, 16'h00FF));
        else n_pass++;
        run_beat("pass_verify", pk(24'h000001, 16'h00FF), 1'b0, 16'h0000, 1'b1, obs, lat);
        n_total++;
        if (obs !== pk(24'h000001, 16'hABCD)) $display("FAIL pass_mem_unchanged: got %h, required %h", obs, pk(24'h000001, 16'hABCD));
        else n_pass++;
    endtask

    task automatic test_both_flags();
        logic [39:0] obs;
        int          lat;
        run_beat("both", pk(24'h818283, 16'h0010), 1'b1, 16'h7777, 1'b1, obs, lat);
        n_total++;
        if (lat !== 1) $display("FAIL both_latency: got %0d, required 1", lat);
        else n_pass++;
        n_total++;
        if (obs !== pk(24'h818283, 16'h0010)) $display("FAIL both_packet: got %h, required %h", obs, pk(24'h818283, 16'h0010));
        else n_pass++;
        run_beat("both_verify", pk(24'h444444, 16'h0010), 1'b0, 16'h0000, 1'b1, obs, lat);
        n_total++;
        if (obs !== pk(24'h444444, 16'h7777)) $display("FAIL both_store_done: got %h, required %h", obs, pk(24'h444444, 16'h7777));
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [39:0] pa = pk(24'hC0FFEE, 16'h1111);
        logic [39:0] pb = pk(24'hD00D00, 16'h2222);
        bus.Ack_in = 1'b0;
        do_accept("bp_a", pa, 1'b0, 16'h0000, 1'b0);
        bus.PACKET_IN = pb;
        bus.Send_in   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CP);
            n_total++;
            if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== pa || bus.Ack_out !== 1'b0)
                $display("FAIL bp_hold_%0d: Send_out=%b PACKET_OUT=%h Ack_out=%b, required 1 %h 0",
                         i, bus.Send_out, bus.PACKET_OUT, bus.Ack_out, pa);
            else
                n_pass++;
        end
        bus.Ack_in = 1'b1;
        #1;
        n_total++;
        if (bus.Ack_out !== 1'b1) $display("FAIL bp_ack_follow: got %b, required 1", bus.Ack_out);
        else n_pass++;
        @(posedge CP);
        #1;
        bus.Send_in = 1'b0;
        @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== pb)
            $display("FAIL bp_next_beat: Send_out=%b PACKET_OUT=%h, required 1 %h", bus.Send_out, bus.PACKET_OUT, pb);
        else
            n_pass++;
        @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b0) $display("FAIL bp_return_idle: got %b, required 0", bus.Send_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [39:0] ps = pk(24'h202020, 16'h0020);
        logic [39:0] pl = pk(24'h303030, 16'h0020);
        logic [39:0] beats [3];
        bus.PACKET_IN  = ps;
        bus.WRITE_EN   = 1'b1;
        bus.WRITE_DATA = 16'hCAFE;
        bus.Send_in    = 1'b1;
        @(posedge CP);
        #1;
        bus.PACKET_IN = pl;
        bus.WRITE_EN  = 1'b0;
        bus.LOAD_FLG  = 1'b1;
        @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== ps || bus.Ack_out !== 1'b1)
            $display("FAIL raw_store_out: Send_out=%b PACKET_OUT=%h Ack_out=%b, required 1 %h 1",
                     bus.Send_out, bus.PACKET_OUT, bus.Ack_out, ps);
        else
            n_pass++;
        @(posedge CP);
        #1;
        bus.Send_in  = 1'b0;
        bus.LOAD_FLG = 1'b0;
        @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b0) $display("FAIL raw_read_bubble: got %b, required 0", bus.Send_out);
        else n_pass++;
        @(negedge CP);
        n_total++;
        if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== pk(24'h303030, 16'hCAFE))
            $display("FAIL raw_load_data: Send_out=%b PACKET_OUT=%h, required 1 %h",
                     bus.Send_out, bus.PACKET_OUT, pk(24'h303030, 16'hCAFE));
        else
            n_pass++;
        @(negedge CP);

        beats[0] = pk(24'h010101, 16'h0A0A);
        beats[1] = pk(24'h020202, 16'h0B0B);
        beats[2] = pk(24'h030303, 16'h0C0C);
        bus.PACKET_IN = beats[0];
        bus.Send_in   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CP);
            #1;
            if (i < 2) bus.PACKET_IN = beats[i+1];
            else       bus.Send_in   = 1'b0;
            @(negedge CP);
            n_total++;
            if (bus.Send_out !== 1'b1 || bus.PACKET_OUT !== beats[i])
                $display("FAIL stream_beat_%0d: Send_out=%b PACKET_OUT=%h, required 1 %h",
                         i, bus.Send_out, bus.PACKET_OUT, beats[i]);
            else
                n_pass++;
        end
        @(negedge CP);
    endtask

    task automatic test_reset_mid_load();
        logic [39:0] obs;
        int          lat;
        logic [15:0] exp_data;
        run_beat("rml_store", pk(24'h000000, 16'h0007), 1'b1, 16'h55AA, 1'b0, obs, lat);
        do_accept("rml_load", pk(24'h999999, 16'h0007), 1'b0, 16'h0000, 1'b1);
        #2;
        MR_N = 1'b0;
        #1;
        n_total++;
        if (bus.Send_out !== 1'b0 || bus.PACKET_OUT !== 40'h0)
            $display("FAIL rml_abort: Send_out=%b PACKET_OUT=%h, required 0 0", bus.Send_out, bus.PACKET_OUT);
        else
            n_pass++;
        n_total++;
        if (bus.Ack_out !== RESET_ACK) $display("FAIL rml_ack: got %b, required %b", bus.Ack_out, RESET_ACK);
        else n_pass++;
        @(negedge CP);
        MR_N = 1'b1;
`ifdef MM_CLEAR_EN
        wait_clear("rml_sweep");
        exp_data = 16'h0000;
`else
        exp_data = 16'h55AA;
`endif
        run_beat("rml_verify", pk(24'h010203, 16'h0007), 1'b0, 16'h0000, 1'b1, obs, lat);
        n_total++;
        if (obs !== pk(24'h010203, exp_data))
            $display("FAIL rml_mem: got %h, required %h", obs, pk(24'h010203, exp_data));
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_pass_through();
        test_both_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
